// File: rtl/cotm32_pkg.sv
`default_nettype none
// cotm32_pkg -- shared execute-stage types and multiply/divide operation helpers
// Rev 1.1
package cotm32_pkg;

  typedef enum logic [3:0] {
    MU_NOP    = 4'd0,
    MU_MUL    = 4'd1,
    MU_MULH   = 4'd2,
    MU_MULHSU = 4'd3,
    MU_MULHU  = 4'd4,
    MU_DIV    = 4'd5,
    MU_DIVU   = 4'd6,
    MU_REM    = 4'd7,
    MU_REMU   = 4'd8
  } mu_op_t;

  function automatic logic mu_is_div(input mu_op_t op);
    return op inside {MU_DIV, MU_DIVU, MU_REM, MU_REMU};
  endfunction

  function automatic logic mu_is_rem(input mu_op_t op);
    return op inside {MU_REM, MU_REMU};
  endfunction

  function automatic logic mu_a_signed(input mu_op_t op);
    return op inside {MU_MUL, MU_MULH, MU_MULHSU, MU_DIV, MU_REM};
  endfunction

  function automatic logic mu_b_signed(input mu_op_t op);
    return op inside {MU_MUL, MU_MULH, MU_DIV, MU_REM};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_div_step.sv
`default_nettype none
// mdu_div_step -- one restoring-division step: shift in a dividend bit, trial-subtract
// Rev 1.0
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            dividend_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem_in < divisor always holds, so diff lies in (-2^XLEN, 2^XLEN) and its top bit is the sign
  assign shifted = {rem_in, dividend_bit};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = ~diff[XLEN];
  assign rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule
`default_nettype wire

// File: rtl/mdu_seq.sv
`default_nettype none
// mdu_seq -- sequential multiply/divide unit: radix-2^MUL_BITS shift-add multiply, restoring divide
// Rev 1.0
module mdu_seq
  import cotm32_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 4,
  parameter int TAG_W    = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  mu_op_t           i_op,
  input  logic [XLEN-1:0]  i_a,
  input  logic [XLEN-1:0]  i_b,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_result,
  output logic [TAG_W-1:0] o_tag
);

  localparam int MUL_STEPS = XLEN / MUL_BITS;
  localparam int CNT_W     = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STEPS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  generate
    if ((XLEN % MUL_BITS) != 0 || (XLEN % 2) != 0 || XLEN < 8) begin : g_param_check
      $error("mdu_seq: unsupported XLEN/MUL_BITS combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  mdu_state_t         state, state_nxt;
  mu_op_t             op;
  logic [TAG_W-1:0]   tag;
  logic [XLEN-1:0]    a_mag;
  logic [XLEN-1:0]    b_mag;
  logic               neg_res;
  logic               special;
  logic [2*XLEN-1:0]  acc;
  logic [CNT_W-1:0]   cnt;
  logic [XLEN-1:0]    result;
  logic [TAG_W-1:0]   out_tag;

  logic               accept;
  logic               sign_a, sign_b;
  logic [XLEN-1:0]    abs_a, abs_b;
  logic               neg_res_in;
  logic               div_by_zero, div_overflow, special_in;
  logic [XLEN-1:0]    special_val;
  logic [2*XLEN-1:0]  partial, partial_sh, prod, prod_fix;
  logic [XLEN-1:0]    rem_next;
  logic               q_bit;
  logic [XLEN-1:0]    quot_fix, rem_fix;

  assign o_ready  = (state == IDLE);
  assign o_valid  = (state == DONE);
  assign o_result = result;
  assign o_tag    = out_tag;

  assign accept = i_valid && o_ready && (i_op != MU_NOP) && !i_flush;

  // Request-side decode: operand magnitudes, result sign and the bypassed divide cases
  assign sign_a = mu_a_signed(i_op) & i_a[XLEN-1];
  assign sign_b = mu_b_signed(i_op) & i_b[XLEN-1];
  assign abs_a  = sign_a ? -i_a : i_a;
  assign abs_b  = sign_b ? -i_b : i_b;
  assign neg_res_in = mu_is_rem(i_op) ? sign_a : (sign_a ^ sign_b);

  assign div_by_zero  = (i_b == '0);
  assign div_overflow = (i_op == MU_DIV || i_op == MU_REM) && (i_a == INT_MIN) && (&i_b);
  assign special_in   = mu_is_div(i_op) && (div_by_zero || div_overflow);

  always_comb begin
    special_val = '0;
    if (div_by_zero) special_val = mu_is_rem(i_op) ? i_a : '1;
    else             special_val = mu_is_rem(i_op) ? '0 : i_a;
  end

  // Shift-add partial product for the next MUL_BITS multiplier bits
  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_BITS; j++) begin
      if (b_mag[j]) partial = partial + ({{XLEN{1'b0}}, a_mag} << j);
    end
  end

  assign partial_sh = partial << (int'(cnt) * MUL_BITS);
  assign prod       = acc + partial_sh;
  assign prod_fix   = neg_res ? -prod : prod;

  mdu_div_step #(
    .XLEN(XLEN)
  ) u_div_step (
    .rem_in      (acc[XLEN-1:0]),
    .dividend_bit(a_mag[XLEN-1]),
    .divisor     (b_mag),
    .rem_out     (rem_next),
    .q_bit       (q_bit)
  );

  assign quot_fix = neg_res ? -a_mag : a_mag;
  assign rem_fix  = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = mu_is_div(i_op) ? DIV : MUL;
      MUL:     if (cnt == MUL_LAST) state_nxt = DONE;
      DIV:     if (special || cnt == DIV_LAST) state_nxt = DONE;
      DONE:    if (i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_flush) state_nxt = IDLE;
  end

  // Shared datapath: acc is the product during MUL and holds the remainder (low half) during DIV,
  // while a_mag shifts out dividend bits and shifts in quotient bits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op      <= MU_NOP;
      tag     <= '0;
      a_mag   <= '0;
      b_mag   <= '0;
      neg_res <= 1'b0;
      special <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      result  <= '0;
      out_tag <= '0;
    end else if (!i_flush) begin
      if (accept) begin
        op      <= i_op;
        tag     <= i_tag;
        a_mag   <= abs_a;
        b_mag   <= abs_b;
        neg_res <= neg_res_in;
        special <= special_in;
        acc     <= special_in ? {{XLEN{1'b0}}, special_val} : '0;
        cnt     <= '0;
      end else if (state == MUL) begin
        acc   <= prod;
        b_mag <= b_mag >> MUL_BITS;
        cnt   <= cnt + CNT_W'(1);
        if (cnt == MUL_LAST) begin
          result  <= (op == MU_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
          out_tag <= tag;
        end
      end else if (state == DIV) begin
        if (special) begin
          result  <= acc[XLEN-1:0];
          out_tag <= tag;
        end else if (cnt == DIV_LAST) begin
          result  <= mu_is_rem(op) ? rem_fix : quot_fix;
          out_tag <= tag;
        end else begin
          acc[XLEN-1:0] <= rem_next;
          a_mag         <= {a_mag[XLEN-2:0], q_bit};
          cnt           <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
// tb_mdu_seq -- self-checking bench for mdu_seq against an arithmetic reference model
// Rev 1.0
module tb_mdu_seq;
  import cotm32_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst, i_flush, i_valid, i_ready;
  mu_op_t      i_op;
  logic [31:0] i_a, i_b;
  logic [4:0]  i_tag;
  logic        o_ready, o_valid;
  logic [31:0] o_result;
  logic [4:0]  o_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_seq #(.XLEN(32), .MUL_BITS(4), .TAG_W(5)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_a(i_a), .i_b(i_b), .i_tag(i_tag), .o_valid(o_valid),
    .i_ready(i_ready), .o_result(o_result), .o_tag(o_tag)
  );

  function automatic logic [31:0] model(input mu_op_t op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic               ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      MU_MUL:    begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[31:0]; end
      MU_MULH:   begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
      MU_MULHSU: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return sp[63:32]; end
      MU_MULHU:  begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      MU_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return $signed(a) / $signed(b);
      end
      MU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MU_REM:    begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return $signed(a) % $signed(b);
      end
      MU_REMU:   return (b == 0) ? a : a % b;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input mu_op_t op, input logic [31:0] a, input logic [31:0] b);
    if (!(op inside {MU_DIV, MU_DIVU, MU_REM, MU_REMU})) return 8;
    if (b == 0) return 1;
    if ((op == MU_DIV || op == MU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Present one request, wait for acceptance, then count edges until o_valid (left in DONE)
  task automatic issue_wait(input mu_op_t op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] t, output int lat);
    int guard = 0;
    while (!o_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    i_valid = 1'b1; i_op = op; i_a = a; i_b = b; i_tag = t;
    @(posedge clk); #1;
    i_valid = 1'b0; i_op = MU_NOP;
    lat = 0;
    while (!o_valid && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic release_result();
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", o_result); end
    checks++; if (o_tag !== 5'd0) begin errors++; $display("FAIL reset_tag got=%h exp=0", o_tag); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
  endtask

  typedef struct {
    mu_op_t      op;
    logic [31:0] a, b, exp;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[11];
    int   lat;
    v[0]  = '{MU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 8};
    v[1]  = '{MU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 8};
    v[2]  = '{MU_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 8};
    v[3]  = '{MU_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    v[4]  = '{MU_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    v[5]  = '{MU_DIVU,   32'd100,        32'd7,         32'd14,        33};
    v[6]  = '{MU_REMU,   32'd100,        32'd7,         32'd2,         33};
    v[7]  = '{MU_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    v[8]  = '{MU_REM,    32'd5,          32'd0,         32'd5,         1};
    v[9]  = '{MU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    v[10] = '{MU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    for (int k = 0; k < 11; k++) begin
      issue_wait(v[k].op, v[k].a, v[k].b, 5'(k + 3), lat);
      checks++; if (o_result !== v[k].exp) begin errors++;
        $display("FAIL directed_result[%0d] got=%h exp=%h", k, o_result, v[k].exp); end
      checks++; if (lat !== v[k].lat) begin errors++;
        $display("FAIL directed_latency[%0d] got=%0d exp=%0d", k, lat, v[k].lat); end
      checks++; if (o_tag !== 5'(k + 3)) begin errors++;
        $display("FAIL directed_tag[%0d] got=%h exp=%h", k, o_tag, 5'(k + 3)); end
      release_result();
    end
  endtask

  task automatic test_random();
    mu_op_t      ops[8] = '{MU_MUL, MU_MULH, MU_MULHSU, MU_MULHU, MU_DIV, MU_DIVU, MU_REM, MU_REMU};
    logic [31:0] corner[5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    mu_op_t      op;
    logic [31:0] a, b, exp;
    logic [4:0]  t;
    int          lat;
    for (int k = 0; k < 48; k++) begin
      op = ops[$urandom_range(0, 7)];
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 28);
      t  = 5'($urandom);
      exp = model(op, a, b);
      issue_wait(op, a, b, t, lat);
      checks++; if (o_result !== exp) begin errors++;
        $display("FAIL random_result op=%0d a=%h b=%h got=%h exp=%h", op, a, b, o_result, exp); end
      checks++; if (o_tag !== t) begin errors++;
        $display("FAIL random_tag got=%h exp=%h", o_tag, t); end
      checks++; if (lat !== model_lat(op, a, b)) begin errors++;
        $display("FAIL random_latency op=%0d got=%0d exp=%0d", op, lat, model_lat(op, a, b)); end
      release_result();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue_wait(MU_MULH, 32'h1234_5678, 32'h8765_4321, 5'd9, lat);
    release_result();
    checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin errors++;
      $display("FAIL b2b_ready_after_handshake got=%b/%b exp=1/0", o_ready, o_valid); end
    issue_wait(MU_DIVU, 32'd1000, 32'd33, 5'd10, lat);
    checks++; if (o_result !== 32'd30 || o_tag !== 5'd10) begin errors++;
      $display("FAIL b2b_second_result got=%h/%h exp=1e/0a", o_result, o_tag); end
    release_result();
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [31:0] exp;
    exp = model(MU_MUL, 32'hDEAD_BEEF, 32'h0000_1234);
    issue_wait(MU_MUL, 32'hDEAD_BEEF, 32'h0000_1234, 5'd17, lat);
    for (int k = 0; k < 10; k++) begin
      checks++; if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_result !== exp || o_tag !== 5'd17) begin errors++;
        $display("FAIL backpressure_hold[%0d] got v=%b r=%b res=%h tag=%h exp v=1 r=0 res=%h tag=11",
                 k, o_valid, o_ready, o_result, o_tag, exp); end
      @(posedge clk); #1;
    end
    release_result();
    checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin errors++;
      $display("FAIL backpressure_release got r=%b v=%b exp r=1 v=0", o_ready, o_valid); end
  endtask

  task automatic test_flush();
    int lat;
    int seen = 0;
    i_valid = 1'b1; i_op = MU_DIV; i_a = 32'd999; i_b = 32'd7; i_tag = 5'd1;
    @(posedge clk); #1;
    i_valid = 1'b0; i_op = MU_NOP;
    repeat (9) @(posedge clk);
    #1;
    i_flush = 1'b1; i_valid = 1'b1; i_op = MU_MUL; i_a = 32'd5; i_b = 32'd5; i_tag = 5'd2;
    @(posedge clk); #1;
    i_flush = 1'b0; i_valid = 1'b0; i_op = MU_NOP;
    checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin errors++;
      $display("FAIL flush_busy got r=%b v=%b exp r=1 v=0", o_ready, o_valid); end
    // Flush while idle with a live request: the request must be dropped
    i_flush = 1'b1; i_valid = 1'b1; i_op = MU_MUL;
    @(posedge clk); #1;
    i_flush = 1'b0; i_valid = 1'b0; i_op = MU_NOP;
    checks++; if (o_ready !== 1'b1) begin errors++;
      $display("FAIL flush_idle_accept got r=%b exp r=1", o_ready); end
    for (int k = 0; k < 40; k++) begin
      if (o_valid) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++;
      $display("FAIL flush_no_valid got=%0d valid cycles exp=0", seen); end
    issue_wait(MU_MUL, 32'd3, 32'd4, 5'd21, lat);
    checks++; if (o_result !== 32'd12 || o_tag !== 5'd21) begin errors++;
      $display("FAIL flush_followup got=%h/%h exp=c/15", o_result, o_tag); end
    release_result();
  endtask

  task automatic test_reset_in_done();
    int lat;
    issue_wait(MU_MUL, 32'd5, 32'd6, 5'd30, lat);
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    checks++; if (o_valid !== 1'b0 || o_result !== 32'd0 || o_tag !== 5'd0 || o_ready !== 1'b1) begin errors++;
      $display("FAIL reset_in_done got v=%b res=%h tag=%h r=%b exp v=0 res=0 tag=0 r=1",
               o_valid, o_result, o_tag, o_ready); end
  endtask

  task automatic test_nop();
    int seen = 0;
    int busy = 0;
    i_valid = 1'b1; i_op = MU_NOP; i_a = 32'd9; i_b = 32'd3;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (o_valid) seen++;
      if (!o_ready) busy++;
    end
    i_valid = 1'b0;
    checks++; if (seen !== 0 || busy !== 0) begin errors++;
      $display("FAIL nop_accepted got valid=%0d busy=%0d exp 0/0", seen, busy); end
  endtask

  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_op = MU_NOP; i_a = '0; i_b = '0; i_tag = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_in_done();
    test_nop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
